// File: rtl/detector_jogada.sv
// detector_jogada: synchronises and debounces the 9 board buttons, accepting a single clean press as a move.
// Optional DETECTOR_ERRO_EN adds erro_multiplo, a 1-cycle pulse on entry to BLOQUEADO.
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zera,
    input  logic [8:0] botoes,
    output logic [8:0] jogada,
    output logic [3:0] jogada_idx,
    output logic       tem_jogada,
`ifdef DETECTOR_ERRO_EN
    output logic       erro_multiplo,
`endif
    output logic [3:0] db_estado
);
    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        FILTRANDO = 3'd1,
        VALIDO    = 3'd2,
        SOLTAR    = 3'd3,
        BLOQUEADO = 3'd4
    } estado_t;
    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] MAXC = CW'(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] ULTIMO = CW'(DEBOUNCE_CICLOS - 1);
    estado_t estado, prox;
    logic [CW-1:0] cnt, cnt_prox, cnt_inc;
    logic [8:0] s1, s2, cand, cand_prox;
    logic vazio, multiplo, unico, ultimo;
    function automatic logic [3:0] indice(input logic [8:0] c);
        indice = 4'd0;
        for (int i = 0; i < 9; i++)
            if (c[i]) indice = 4'(i + 1);
    endfunction
    assign vazio    = s2 == 9'd0;
    assign multiplo = (s2 & (s2 - 9'd1)) != 9'd0;
    assign unico    = !vazio && !multiplo;
    assign ultimo   = cnt == ULTIMO;
    assign cnt_inc  = (cnt == MAXC) ? cnt : cnt + 1'b1;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1     <= '0;
            s2     <= '0;
            estado <= SOLTAR;
            cnt    <= '0;
            cand   <= '0;
            jogada <= '0;
        end else if (zera) begin
            s1     <= '0;
            s2     <= '0;
            estado <= SOLTAR;
            cnt    <= '0;
            cand   <= '0;
            jogada <= '0;
        end else begin
            s1     <= botoes;
            s2     <= s1;
            estado <= prox;
            cnt    <= cnt_prox;
            cand   <= cand_prox;
            jogada <= (prox == VALIDO) ? cand : jogada;
        end
    end
    always_comb begin
        prox      = SOLTAR;
        cnt_prox  = '0;
        cand_prox = cand;
        case (estado)
            OCIOSO: begin
                cand_prox = s2;
                prox      = unico ? FILTRANDO : multiplo ? BLOQUEADO : OCIOSO;
            end
            FILTRANDO: begin
                if (multiplo) prox = BLOQUEADO;
                else if (vazio) prox = OCIOSO;
                else if (s2 != cand) begin
                    cand_prox = s2;
                    prox      = FILTRANDO;
                end else begin
                    cnt_prox = cnt_inc;
                    prox     = ultimo ? VALIDO : FILTRANDO;
                end
            end
            VALIDO:    prox = SOLTAR;
            SOLTAR: begin
                cnt_prox = vazio ? cnt_inc : '0;
                prox     = (vazio && ultimo) ? OCIOSO : SOLTAR;
            end
            BLOQUEADO: prox = vazio ? SOLTAR : BLOQUEADO;
            default:   prox = SOLTAR;
        endcase
    end
    // zera in the VALIDO cycle cancels the strobe before the control unit can see it
    always_comb begin
        tem_jogada = (estado == VALIDO) && !zera;
        jogada_idx = indice(jogada);
        db_estado  = {1'b0, estado};
    end
`ifdef DETECTOR_ERRO_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) erro_multiplo <= 1'b0;
        else erro_multiplo <= !zera && (prox == BLOQUEADO) && (estado != BLOQUEADO);
    end
`endif
endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: table-driven vectors plus corner sequences; strobes checked against a timed scoreboard.
module tb_detector_jogada;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       zera = 1'b0;
    logic [8:0] botoes = '0;
    logic [8:0] jogada;
    logic [3:0] jogada_idx;
    logic       tem_jogada;
    logic [3:0] db_estado;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
`ifdef DETECTOR_ERRO_EN
    logic erro_multiplo;
    int   erro_n = 0;
`endif
    detector_jogada #(.DEBOUNCE_CICLOS(4)) dut (
        .clock(clk),
        .reset(rst_n),
        .zera(zera),
        .botoes(botoes),
        .jogada(jogada),
        .jogada_idx(jogada_idx),
        .tem_jogada(tem_jogada),
`ifdef DETECTOR_ERRO_EN
        .erro_multiplo(erro_multiplo),
`endif
        .db_estado(db_estado)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        logic [8:0] j;
        logic [3:0] idx;
        int         cyc;
    } exp_t;
    exp_t sb[$];
    typedef struct {
        logic [8:0] b;
        int         hold;
        int         rel;
        bit         strobe;
        logic [3:0] est;
        logic [8:0] jog;
        logic [3:0] idx;
    } vec_t;
    vec_t tab[8];
    // strobe is due in the cycle after edge t0+6, i.e. when cyc reaches drive_cycle+7
    task automatic expect_strobe(input logic [8:0] j, input logic [3:0] idx);
        exp_t e;
        e.j = j;
        e.idx = idx;
        e.cyc = cyc + 7;
        sb.push_back(e);
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe: none by cycle %0d for jogada %0h", sb[0].cyc, sb[0].j);
            void'(sb.pop_front());
        end
        if (tem_jogada) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cycle %0d jogada %0h expected no strobe", cyc, jogada);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (jogada !== e.j || jogada_idx !== e.idx || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe: got jogada=%0h idx=%0d cyc=%0d expected %0h %0d %0d",
                             jogada, jogada_idx, cyc, e.j, e.idx, e.cyc);
                end
            end
        end
`ifdef DETECTOR_ERRO_EN
        if (erro_multiplo) erro_n++;
`endif
    end
    initial begin
        tab[0] = '{9'h010, 10, 10, 1'b1, 4'd3, 9'h010, 4'd5};
        tab[1] = '{9'h001, 3, 10, 1'b0, 4'd1, 9'h010, 4'd5};
        tab[2] = '{9'h003, 6, 10, 1'b0, 4'd4, 9'h010, 4'd5};
        tab[3] = '{9'h100, 8, 10, 1'b1, 4'd3, 9'h100, 4'd9};
        tab[4] = '{9'h1FF, 6, 10, 1'b0, 4'd4, 9'h100, 4'd9};
        tab[5] = '{9'h002, 8, 10, 1'b1, 4'd3, 9'h002, 4'd2};
        tab[6] = '{9'h080, 8, 10, 1'b1, 4'd3, 9'h080, 4'd8};
        tab[7] = '{9'h040, 8, 10, 1'b1, 4'd3, 9'h040, 4'd7};
        tick(3);
        check("reset_jogada", 16'(jogada), 16'h0);
        check("reset_idx", 16'(jogada_idx), 16'h0);
        check("reset_tem", 16'(tem_jogada), 16'h0);
        check("reset_estado", 16'(db_estado), 16'h3);
        rst_n = 1'b1;
        tick(6);
        check("idle_after_reset", 16'(db_estado), 16'h0);
        for (int i = 0; i < 8; i++) begin
            botoes = tab[i].b;
            if (tab[i].strobe) expect_strobe(tab[i].b, tab[i].idx);
            tick(tab[i].hold);
            check($sformatf("vec%0d_estado_held", i), 16'(db_estado), 16'(tab[i].est));
            botoes = '0;
            tick(tab[i].rel);
            check($sformatf("vec%0d_estado_idle", i), 16'(db_estado), 16'h0);
            check($sformatf("vec%0d_jogada", i), 16'(jogada), 16'(tab[i].jog));
            check($sformatf("vec%0d_idx", i), 16'(jogada_idx), 16'(tab[i].idx));
        end
`ifdef DETECTOR_ERRO_EN
        check("erro_pulses", 16'(erro_n), 16'd2);
`endif
        // button held through reset must be released before it can count
        botoes = 9'h004;
        rst_n = 1'b0;
        tick(2);
        check("held_reset_jogada", 16'(jogada), 16'h0);
        rst_n = 1'b1;
        tick(12);
        check("held_reset_soltar", 16'(db_estado), 16'h3);
        botoes = '0;
        tick(10);
        check("held_reset_idle", 16'(db_estado), 16'h0);
        botoes = 9'h004;
        expect_strobe(9'h004, 4'd3);
        tick(8);
        botoes = '0;
        tick(10);
        check("held_reset_idx", 16'(jogada_idx), 16'd3);
        // zera in the VALIDO cycle
        botoes = 9'h020;
        tick(7);
        check("zera_at_valido", 16'(db_estado), 16'h2);
        zera = 1'b1;
        #1;
        check("zera_tem", 16'(tem_jogada), 16'h0);
        tick(1);
        zera = 1'b0;
        check("zera_jogada", 16'(jogada), 16'h0);
        check("zera_idx", 16'(jogada_idx), 16'h0);
        check("zera_estado", 16'(db_estado), 16'h3);
        botoes = '0;
        tick(10);
        // short release after a strobe does not re-arm
        botoes = 9'h002;
        expect_strobe(9'h002, 4'd2);
        tick(8);
        botoes = '0;
        tick(2);
        botoes = 9'h002;
        tick(10);
        check("short_release_soltar", 16'(db_estado), 16'h3);
        botoes = '0;
        tick(10);
        check("short_release_idle", 16'(db_estado), 16'h0);
        // press glitch restarts filtering from the re-press
        botoes = 9'h008;
        tick(3);
        botoes = '0;
        tick(1);
        botoes = 9'h008;
        expect_strobe(9'h008, 4'd4);
        tick(10);
        botoes = '0;
        tick(10);
        check("glitch_idx", 16'(jogada_idx), 16'd4);
        check("scoreboard_empty", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
